softex_stream_packer: RTL



---
 rtl/softex_stream_packer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/softex_stream_packer.sv
// -----------------------------------------------------------------------------
// softex_stream_packer
//
// Lane compaction stage between the input-stream FIFO and the SoftEx datapath.
// Input beats carry a low-aligned prefix of valid lanes, and a beat may be
// partial (row tails, casted sub-beats). This block repacks them into dense
// full-width beats. Only the final beat of a row, flagged by out_last_o, may
// be partial.
//
// Optional feature (compile-time macro):
//   SOFTEX_PACKER_STRB_CHECK_EN
//     Defined:   a non-prefix in_strb_i, or an empty beat without in_last_i,
//                is accepted and discarded, and the sticky error_o is set.
//     Undefined: error_o is tied to 0. Only the leading ones of in_strb_i
//                count as valid lanes.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous soft clear (beats handshake)
//   in_data_i/in_strb_i      input beat and its per-lane valid mask
//   in_last_i                final beat of a row
//   in_valid_i/in_ready_o    input handshake
//   out_data_o/out_strb_o    packed beat and its prefix valid mask
//   out_last_o               final beat of a row
//   out_valid_o/out_ready_i  output handshake
//   busy_o                   data held internally
//   error_o                  sticky strobe-format error
// -----------------------------------------------------------------------------
module softex_stream_packer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ELEM_WIDTH = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic [DATA_WIDTH-1:0]              in_data_i,
  input  logic [DATA_WIDTH/ELEM_WIDTH-1:0]   in_strb_i,
  input  logic                               in_last_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic [DATA_WIDTH-1:0]              out_data_o,
  output logic [DATA_WIDTH/ELEM_WIDTH-1:0]   out_strb_o,
  output logic                               out_last_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               busy_o,
  output logic                               error_o
);

  localparam int unsigned LANES = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned CW    = $clog2(LANES + 1);

  typedef logic [CW-1:0]    cnt_t;   // lane count 0..LANES
  typedef logic [CW:0]      tot_t;   // residue + input, up to 2*LANES-1
  typedef logic [LANES-1:0] strb_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Mask with lanes 0..n-1 set.
  function automatic strb_t prefix_mask(input tot_t n);
    strb_t m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (tot_t'(i) < n);
    end
    return m;
  endfunction

  // Number of consecutive set lanes starting at lane 0.
  function automatic cnt_t lead_ones(input strb_t s);
    cnt_t k;
    logic run;
    k   = cnt_t'(0);
    run = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (run && s[i]) begin
        k = k + cnt_t'(1);
      end else begin
        run = 1'b0;
      end
    end
    return k;
  endfunction

  // Widen a lane mask to a bit mask over the data word.
  function automatic logic [DATA_WIDTH-1:0] lane_expand(input strb_t m);
    logic [DATA_WIDTH-1:0] e;
    for (int i = 0; i < LANES; i++) begin
      e[i*ELEM_WIDTH +: ELEM_WIDTH] = {ELEM_WIDTH{m[i]}};
    end
    return e;
  endfunction

`ifdef SOFTEX_PACKER_STRB_CHECK_EN
  // A legal prefix mask has no set bit above a clear one.
  function automatic logic is_prefix(input strb_t s);
    return ((s & (s + strb_t'(1))) == strb_t'(0));
  endfunction
`endif

  state_e                  state_r;
  logic [DATA_WIDTH-1:0]   res_r;
  cnt_t                    cnt_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  strb_t                   out_strb_r;
  logic                    out_last_r;
  logic                    out_valid_r;
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
  logic                    error_r;
`endif

  cnt_t                    k_s;
  logic                    bad_s;
  logic [DATA_WIDTH-1:0]   in_masked_s;
  logic [31:0]             shamt_s;
  logic [2*DATA_WIDTH-1:0] wide_s;
  logic [DATA_WIDTH-1:0]   lo_s;
  logic [DATA_WIDTH-1:0]   hi_s;
  tot_t                    total_s;
  logic                    full_s;
  cnt_t                    rem_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic                    consume_s;

  // Merge the residue with the incoming lanes: the input is shifted up past
  // the residue so lo_s is the next output beat and hi_s the carry-over.
  // Residue lanes above cnt_r are always zero, so a plain OR suffices.
  always_comb begin
    k_s = lead_ones(in_strb_i);
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
    bad_s = !is_prefix(in_strb_i) || ((k_s == cnt_t'(0)) && !in_last_i);
`else
    bad_s = 1'b0;
`endif
    in_masked_s = in_data_i & lane_expand(prefix_mask(tot_t'(k_s)));
    shamt_s     = 32'(cnt_r) * 32'(ELEM_WIDTH);
    wide_s      = ({{DATA_WIDTH{1'b0}}, in_masked_s} << shamt_s)
                | {{DATA_WIDTH{1'b0}}, res_r};
    lo_s        = wide_s[DATA_WIDTH-1:0];
    hi_s        = wide_s[2*DATA_WIDTH-1:DATA_WIDTH];
    total_s     = tot_t'(cnt_r) + tot_t'(k_s);
    full_s      = (total_s >= tot_t'(LANES));
    rem_s       = cnt_t'(total_s - tot_t'(LANES));
    in_ready_s  = (state_r == RUN) && (!out_valid_r || out_ready_i);
    accept_s    = in_valid_i && in_ready_s;
    consume_s   = out_valid_r && out_ready_i;
  end

  // Packing FSM: residue, output register and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RUN;
      res_r       <= '0;
      cnt_r       <= cnt_t'(0);
      out_data_r  <= '0;
      out_strb_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
      error_r     <= 1'b0;
`endif
    end else if (clear_i) begin
      state_r     <= RUN;
      res_r       <= '0;
      cnt_r       <= cnt_t'(0);
      out_data_r  <= '0;
      out_strb_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
      error_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        RUN: begin
          // Drop the held beat once taken; a new beat below may reload it.
          if (consume_s) begin
            out_valid_r <= 1'b0;
          end
          if (accept_s && !bad_s) begin
            if (full_s) begin
              out_data_r  <= lo_s;
              out_strb_r  <= '1;
              out_valid_r <= 1'b1;
              res_r       <= hi_s;
              cnt_r       <= rem_s;
              // A row ending with leftover lanes needs one more beat.
              if (in_last_i && (rem_s != cnt_t'(0))) begin
                out_last_r <= 1'b0;
                state_r    <= FLUSH;
              end else begin
                out_last_r <= in_last_i;
              end
            end else if (in_last_i) begin
              out_data_r  <= lo_s;
              out_strb_r  <= prefix_mask(total_s);
              out_last_r  <= 1'b1;
              out_valid_r <= 1'b1;
              res_r       <= '0;
              cnt_r       <= cnt_t'(0);
            end else begin
              res_r <= lo_s;
              cnt_r <= cnt_t'(total_s);
            end
          end
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
          else if (accept_s) begin
            error_r <= 1'b1;
          end
`endif
        end
        FLUSH: begin
          // out_valid_r is always set here; emit the residue as row tail.
          if (out_ready_i) begin
            out_data_r  <= res_r;
            out_strb_r  <= prefix_mask(tot_t'(cnt_r));
            out_last_r  <= 1'b1;
            out_valid_r <= 1'b1;
            res_r       <= '0;
            cnt_r       <= cnt_t'(0);
            state_r     <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_data_o  = out_data_r;
  assign out_strb_o  = out_strb_r;
  assign out_last_o  = out_last_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = out_valid_r || (cnt_r != cnt_t'(0)) || (state_r == FLUSH);
`ifdef SOFTEX_PACKER_STRB_CHECK_EN
  assign error_o     = error_r;
`else
  assign error_o     = 1'b0;
`endif

endmodule
